// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the pipeline MEM stage and mem_access_unit.
// The master side is the pipeline; the slave side is the access unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_signed,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_signed,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-port, word-addressed data memory with 1-cycle read.
// Define LSU_BYTE_EN for byte/half accesses (sub-word stores become read-modify-write).
module mem_access_unit #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Write_data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] Read_data
);

  localparam int unsigned RANGE_LSB = ADDR_W + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t state, state_next;
  logic   accept_c;
  logic   range_err_c;
  logic   misalign_c;
  logic   err_c;
  logic   resp_err_next;

  assign accept_c    = (state == IDLE) && bus.req_valid;
  assign range_err_c = (bus.req_addr >> RANGE_LSB) != 32'd0;
  assign err_c       = range_err_c || misalign_c;

`ifdef LSU_BYTE_EN
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              write_q;
  logic              subword_c;
  logic [4:0]        shamt_c;
  logic [DATA_W-1:0] shifted_c;
  logic [DATA_W-1:0] load_c;
  logic [DATA_W-1:0] mask_c;
  logic [DATA_W-1:0] merge_c;

  assign subword_c = (bus.req_size != 2'b10);

  always_comb begin
    misalign_c = 1'b0;
    case (bus.req_size)
      2'b00:   misalign_c = 1'b0;
      2'b01:   misalign_c = bus.req_addr[0];
      2'b10:   misalign_c = |bus.req_addr[1:0];
      default: misalign_c = 1'b1;
    endcase
  end

  // Lane extraction for loads and lane merge for read-modify-write stores.
  assign shamt_c   = {lane_q, 3'b000};
  assign shifted_c = Read_data >> shamt_c;

  always_comb begin
    load_c = Read_data;
    case (size_q)
      2'b00:   load_c = signed_q ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                                 : {24'd0, shifted_c[7:0]};
      2'b01:   load_c = signed_q ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                                 : {16'd0, shifted_c[15:0]};
      default: load_c = Read_data;
    endcase
  end

  assign mask_c  = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt_c;
  assign merge_c = (Read_data & ~mask_c) | ((Write_data << shamt_c) & mask_c);
`else
  logic unused_subword;

  assign misalign_c     = |bus.req_addr[1:0];
  assign unused_subword = ^{bus.req_size, bus.req_signed};
`endif

  // Next-state and error-response decode.
  always_comb begin
    state_next    = state;
    resp_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (err_c) begin
            state_next    = RESP;
            resp_err_next = 1'b1;
          end else if (bus.req_write) begin
`ifdef LSU_BYTE_EN
            state_next = subword_c ? RD : WR;
`else
            state_next = WR;
`endif
          end else begin
            state_next = RD;
          end
        end
      end
      RD:   state_next = CAP;
`ifdef LSU_BYTE_EN
      CAP:  state_next = write_q ? WR : RESP;
`else
      CAP:  state_next = RESP;
`endif
      WR:   state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus strobes/handshake registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      MemRead        <= 1'b0;
      MemWrite       <= 1'b0;
    end else begin
      state          <= state_next;
      bus.req_ready  <= (state_next == IDLE);
      bus.resp_valid <= (state_next == RESP);
      bus.resp_err   <= resp_err_next;
      MemRead        <= (state_next == RD);
      MemWrite       <= (state_next == WR);
    end
  end

  // Request capture and read-data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Address       <= '0;
      Write_data    <= '0;
      bus.resp_data <= '0;
`ifdef LSU_BYTE_EN
      lane_q        <= 2'd0;
      size_q        <= 2'd0;
      signed_q      <= 1'b0;
      write_q       <= 1'b0;
`endif
    end else begin
      if (accept_c) begin
        Address    <= ADDR_W'(bus.req_addr >> 2);
        Write_data <= bus.req_wdata;
`ifdef LSU_BYTE_EN
        lane_q     <= bus.req_addr[1:0];
        size_q     <= bus.req_size;
        signed_q   <= bus.req_signed;
        write_q    <= bus.req_write;
`endif
      end
      if (state == CAP) begin
`ifdef LSU_BYTE_EN
        if (write_q) Write_data <= merge_c;
        else         bus.resp_data <= load_c;
`else
        bus.resp_data <= Read_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural 1-cycle-read memory.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 7;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       Write_data;
  logic              MemWrite;
  logic              MemRead;
  logic [31:0]       Read_data;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .Address    (Address),
    .Write_data (Write_data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Read_data  (Read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with a backdoor preload port.
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [31:0]       pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (MemWrite) mem[Address] <= Write_data;
    if (MemRead) Read_data <= mem[Address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request; check latency, error flag, strobes seen, address, and resp_data.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                        input int exp_lat, input logic exp_err, input logic [1:0] exp_strobes,
                        input logic [31:0] exp_data);
    int          lat;
    logic        saw_r, saw_w, both;
    logic [31:0] first_addr;
    @(negedge clk);
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_size = size; bus.req_signed = sgn;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; saw_r = 1'b0; saw_w = 1'b0; both = 1'b0;
    first_addr = 32'(Address);
    while (!bus.resp_valid && lat < 10) begin
      saw_r = saw_r | MemRead;
      saw_w = saw_w | MemWrite;
      both  = both | (MemRead & MemWrite);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " resp_err"}, 32'(bus.resp_err), 32'(exp_err));
    chk({tag, " strobes"}, 32'({saw_w, saw_r}), 32'(exp_strobes));
    chk({tag, " strobe_overlap"}, 32'(both), 32'd0);
    if (!exp_err) chk({tag, " address"}, first_addr, 32'(addr[ADDR_W+1:2]));
    if (!wr || exp_err) chk({tag, " resp_data"}, bus.resp_data, exp_data);
  endtask

  initial begin
    rst_n = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h34;
    bus.req_wdata = 32'h0; bus.req_size = 2'b10; bus.req_signed = 1'b0;

    // Reset held with a request pending: nothing happens.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst strobes", 32'({MemWrite, MemRead}), 32'd0);
      chk("rst ready", 32'(bus.req_ready), 32'd1);
      chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    end
    chk("rst address", 32'(Address), 32'd0);
    chk("rst write_data", Write_data, 32'd0);
    chk("rst resp_data", bus.resp_data, 32'd0);
    bus.req_valid = 1'b0;
    preload(7'd13, 32'd3);
    preload(7'd127, 32'hCAFE_F00D);
    preload(7'd4, 32'h55AA_55AA);
    @(negedge clk);
    rst_n = 1'b1;

    do_req("load34", 1'b0, 32'h34, 32'h0, 2'b10, 1'b0, 3, 1'b0, 2'b01, 32'd3);
    do_req("store08", 1'b1, 32'h08, 32'hDEAD_BEEF, 2'b10, 1'b0, 2, 1'b0, 2'b10, 32'd0);
    chk("mem2 after store", mem[2], 32'hDEAD_BEEF);
    do_req("load08", 1'b0, 32'h08, 32'h0, 2'b10, 1'b0, 3, 1'b0, 2'b01, 32'hDEAD_BEEF);
    do_req("err35", 1'b0, 32'h35, 32'h0, 2'b10, 1'b0, 1, 1'b1, 2'b00, 32'hDEAD_BEEF);
    do_req("err200", 1'b0, 32'h200, 32'h0, 2'b10, 1'b0, 1, 1'b1, 2'b00, 32'hDEAD_BEEF);
    do_req("load1fc", 1'b0, 32'h1FC, 32'h0, 2'b10, 1'b0, 3, 1'b0, 2'b01, 32'hCAFE_F00D);
    do_req("st_err06", 1'b1, 32'h06, 32'h1234, 2'b10, 1'b0, 1, 1'b1, 2'b00, 32'hCAFE_F00D);
    do_req("st_err_hi", 1'b1, 32'h8000_0010, 32'h1234, 2'b10, 1'b0, 1, 1'b1, 2'b00, 32'hCAFE_F00D);
    chk("mem4 untouched", mem[4], 32'h55AA_55AA);

`ifdef LSU_BYTE_EN
    preload(7'd2, 32'h1122_3380);
    do_req("lb08", 1'b0, 32'h08, 32'h0, 2'b00, 1'b1, 3, 1'b0, 2'b01, 32'hFFFF_FF80);
    do_req("sb09", 1'b1, 32'h09, 32'hAA, 2'b00, 1'b0, 4, 1'b0, 2'b11, 32'd0);
    chk("mem2 after sb", mem[2], 32'h1122_AA80);
    do_req("lhu0a", 1'b0, 32'h0A, 32'h0, 2'b01, 1'b0, 3, 1'b0, 2'b01, 32'h0000_1122);
    do_req("err_size3", 1'b0, 32'h08, 32'h0, 2'b11, 1'b0, 1, 1'b1, 2'b00, 32'h0000_1122);
`endif

    // Reset dropped during the WR cycle of a store: no write, no response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'h1234_5678; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("midrst memwrite before", 32'(MemWrite), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("midrst memwrite async", 32'(MemWrite), 32'd0);
    @(negedge clk);
    chk("midrst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst mem4", mem[4], 32'h55AA_55AA);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst ready", 32'(bus.req_ready), 32'd1);
    chk("midrst resp_valid after", 32'(bus.resp_valid), 32'd0);
    chk("midrst strobes after", 32'({MemWrite, MemRead}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
